// File: rtl/ub_pkg.sv
// Shared widths and FSM state types for the Unified_Buffer access scheduler.
package ub_pkg;

  localparam int unsigned UB_ADDR_W = 15;
  localparam int unsigned UB_DATA_W = 64;
  localparam int unsigned UB_LEN_W  = 8;

  typedef logic [UB_LEN_W-1:0] ub_len_t;

  typedef enum logic {
    WIdle,
    WBurst
  } wr_state_e;

  typedef enum logic {
    RIdle,
    RBurst
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational onehot grant of the first requester at/after the pointer;
// the pointer moves past the winner when advance_i is pulsed.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_q) + i) % N;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IdxW'(k);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (32'(idx_o) == N - 1) ? '0 : idx_o + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ub_access_scheduler.sv
// Burst scheduler in front of the Unified_Buffer: round-robin write bursts from NUM_WR masters
// and an independent read burst engine with a one-cycle valid/last pipe matching UB latency.
module ub_access_scheduler
  import ub_pkg::*;
#(
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned DATA_W = UB_DATA_W,
  parameter int unsigned ADDR_W = UB_ADDR_W,
  parameter int unsigned LEN_W  = UB_LEN_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WR-1:0]        wr_req_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_base_i,
  input  logic [NUM_WR*LEN_W-1:0]  wr_len_i,
  output logic [NUM_WR-1:0]        wr_gnt_o,
  input  logic [NUM_WR-1:0]        wr_valid_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  output logic [NUM_WR-1:0]        wr_ready_o,
  output logic [NUM_WR-1:0]        wr_done_o,
  input  logic                     rd_cmd_valid_i,
  output logic                     rd_cmd_ready_o,
  input  logic [ADDR_W-1:0]        rd_base_i,
  input  logic [LEN_W-1:0]         rd_len_i,
  input  logic                     rd_stall_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     rd_last_o,
  output logic                     ub_write_o,
  output logic [ADDR_W-1:0]        ub_addr_wr_o,
  output logic [DATA_W-1:0]        ub_data_o,
  output logic                     ub_read_o,
  output logic [ADDR_W-1:0]        ub_addr_rd_o,
  input  logic [DATA_W-1:0]        ub_data_i
);

  localparam int unsigned IdxW = $clog2(NUM_WR);

  wr_state_e         wr_state_q, wr_state_d;
  logic [IdxW-1:0]   wr_own_q, wr_own_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              rd_issue_last;
  logic              rd_valid_q, rd_last_q;

  logic [NUM_WR-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_adv;

  rr_arbiter #(
    .N (NUM_WR)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (wr_req_i),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx)
  );

  // Write side; rst_i gating keeps every output low while reset is held.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_own_d     = wr_own_q;
    wr_addr_d    = wr_addr_q;
    wr_cnt_d     = wr_cnt_q;
    arb_adv      = 1'b0;
    wr_gnt_o     = '0;
    wr_ready_o   = '0;
    wr_done_o    = '0;
    ub_write_o   = 1'b0;
    ub_addr_wr_o = '0;
    ub_data_o    = '0;
    if (!rst_i) begin
      unique case (wr_state_q)
        WIdle: begin
          if (|wr_req_i) begin
            arb_adv    = 1'b1;
            wr_gnt_o   = arb_gnt;
            wr_own_d   = arb_idx;
            wr_addr_d  = wr_base_i[arb_idx*ADDR_W +: ADDR_W];
            wr_cnt_d   = wr_len_i[arb_idx*LEN_W +: LEN_W];
            wr_state_d = WBurst;
          end
        end
        WBurst: begin
          wr_ready_o[wr_own_q] = 1'b1;
          if (wr_valid_i[wr_own_q]) begin
            ub_write_o   = 1'b1;
            ub_addr_wr_o = wr_addr_q;
            ub_data_o    = wr_data_i[wr_own_q*DATA_W +: DATA_W];
            wr_addr_d    = wr_addr_q + ADDR_W'(1);
            if (wr_cnt_q == '0) begin
              wr_done_o[wr_own_q] = 1'b1;
              wr_state_d          = WIdle;
            end else begin
              wr_cnt_d = wr_cnt_q - LEN_W'(1);
            end
          end
        end
        default: wr_state_d = WIdle;
      endcase
    end
  end

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_addr_d      = rd_addr_q;
    rd_cnt_d       = rd_cnt_q;
    rd_cmd_ready_o = 1'b0;
    ub_read_o      = 1'b0;
    ub_addr_rd_o   = '0;
    rd_issue_last  = 1'b0;
    if (!rst_i) begin
      unique case (rd_state_q)
        RIdle: begin
          rd_cmd_ready_o = 1'b1;
          if (rd_cmd_valid_i) begin
            rd_addr_d  = rd_base_i;
            rd_cnt_d   = rd_len_i;
            rd_state_d = RBurst;
          end
        end
        RBurst: begin
          if (!rd_stall_i) begin
            ub_read_o    = 1'b1;
            ub_addr_rd_o = rd_addr_q;
            rd_addr_d    = rd_addr_q + ADDR_W'(1);
            if (rd_cnt_q == '0) begin
              rd_issue_last = 1'b1;
              rd_state_d    = RIdle;
            end else begin
              rd_cnt_d = rd_cnt_q - LEN_W'(1);
            end
          end
        end
        default: rd_state_d = RIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= WIdle;
      wr_own_q   <= '0;
      wr_addr_q  <= '0;
      wr_cnt_q   <= '0;
      rd_state_q <= RIdle;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_own_q   <= wr_own_d;
      wr_addr_q  <= wr_addr_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_valid_q <= ub_read_o;
      rd_last_q  <= rd_issue_last;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_data_o  = rd_valid_q ? ub_data_i : '0;

endmodule

// File: tb/tb_ub_access_scheduler.sv
// Directed bench for ub_access_scheduler with a UB memory model and write/read scoreboards.
module tb_ub_access_scheduler;

  localparam int NW = 2;
  localparam int DW = 64;
  localparam int AW = 15;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NW-1:0]    wr_req_i = '0;
  logic [NW*AW-1:0] wr_base_i = '0;
  logic [NW*LW-1:0] wr_len_i = '0;
  logic [NW-1:0]    wr_gnt_o;
  logic [NW-1:0]    wr_valid_i = '0;
  logic [NW*DW-1:0] wr_data_i = '0;
  logic [NW-1:0]    wr_ready_o;
  logic [NW-1:0]    wr_done_o;
  logic             rd_cmd_valid_i = 1'b0;
  logic             rd_cmd_ready_o;
  logic [AW-1:0]    rd_base_i = '0;
  logic [LW-1:0]    rd_len_i = '0;
  logic             rd_stall_i = 1'b0;
  logic [DW-1:0]    rd_data_o;
  logic             rd_valid_o;
  logic             rd_last_o;
  logic             ub_write_o;
  logic [AW-1:0]    ub_addr_wr_o;
  logic [DW-1:0]    ub_data_o;
  logic             ub_read_o;
  logic [AW-1:0]    ub_addr_rd_o;
  logic [DW-1:0]    ub_data_i = '0;

  ub_access_scheduler #(
    .NUM_WR (NW),
    .DATA_W (DW),
    .ADDR_W (AW),
    .LEN_W  (LW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_req_i       (wr_req_i),
    .wr_base_i      (wr_base_i),
    .wr_len_i       (wr_len_i),
    .wr_gnt_o       (wr_gnt_o),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .wr_done_o      (wr_done_o),
    .rd_cmd_valid_i (rd_cmd_valid_i),
    .rd_cmd_ready_o (rd_cmd_ready_o),
    .rd_base_i      (rd_base_i),
    .rd_len_i       (rd_len_i),
    .rd_stall_i     (rd_stall_i),
    .rd_data_o      (rd_data_o),
    .rd_valid_o     (rd_valid_o),
    .rd_last_o      (rd_last_o),
    .ub_write_o     (ub_write_o),
    .ub_addr_wr_o   (ub_addr_wr_o),
    .ub_data_o      (ub_data_o),
    .ub_read_o      (ub_read_o),
    .ub_addr_rd_o   (ub_addr_rd_o),
    .ub_data_i      (ub_data_i)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rd_exp_t;

  wr_exp_t       wr_q[$];
  logic [AW-1:0] rda_q[$];
  rd_exp_t       rd_q[$];

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Per-cycle expectations, cleared after every sampled cycle.
  logic [NW-1:0] exp_gnt = '0;
  logic [NW-1:0] exp_ready = '0;
  logic [NW-1:0] exp_done = '0;
  bit            chk_rdy = 1'b0;
  logic          exp_rdy = 1'b0;
  bit            chk_rdo = 1'b0;
  logic          exp_rdo = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit c);
    n_assert++;
    assert (c) else begin
      n_fail++;
      $error("FAIL %s: observed 0 expected 1", tag);
    end
  endtask

  task automatic tick();
    wr_exp_t       we;
    rd_exp_t       re;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd_next;
    bit            rd_pend;
    rd_next = '0;
    @(negedge clk);
    chk("wr_gnt", 64'(wr_gnt_o), 64'(exp_gnt));
    chk("wr_ready", 64'(wr_ready_o), 64'(exp_ready));
    chk("wr_done", 64'(wr_done_o), 64'(exp_done));
    if (chk_rdy) chk("rd_cmd_ready", 64'(rd_cmd_ready_o), 64'(exp_rdy));
    if (chk_rdo) chk("ub_read", 64'(ub_read_o), 64'(exp_rdo));
    if (ub_write_o) begin
      chk_true("wr_beat_expected", wr_q.size() != 0);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        chk("ub_addr_wr", 64'(ub_addr_wr_o), 64'(we.addr));
        chk("ub_data", ub_data_o, we.data);
      end
    end
    if (ub_read_o) begin
      chk_true("rd_issue_expected", rda_q.size() != 0);
      if (rda_q.size() != 0) begin
        ra = rda_q.pop_front();
        chk("ub_addr_rd", 64'(ub_addr_rd_o), 64'(ra));
      end
    end
    if (rd_valid_o) begin
      chk_true("rd_beat_expected", rd_q.size() != 0);
      if (rd_q.size() != 0) begin
        re = rd_q.pop_front();
        chk("rd_data", rd_data_o, re.data);
        chk("rd_last", 64'(rd_last_o), 64'(re.last));
      end
    end else begin
      chk("rd_last_without_valid", 64'(rd_last_o), 64'd0);
    end
    // UB model: read-first, one-cycle read latency, data holds otherwise.
    rd_pend = ub_read_o;
    if (ub_read_o) rd_next = mem[ub_addr_rd_o];
    if (ub_write_o) mem[ub_addr_wr_o] = ub_data_o;
    exp_gnt   = '0;
    exp_ready = '0;
    exp_done  = '0;
    chk_rdy   = 1'b0;
    chk_rdo   = 1'b0;
    @(posedge clk);
    #1;
    if (rd_pend) ub_data_i = rd_next;
  endtask

  task automatic wr_cmd(input int idx, input logic [AW-1:0] base, input logic [LW-1:0] len);
    wr_req_i[idx]           = 1'b1;
    wr_base_i[idx*AW +: AW] = base;
    wr_len_i[idx*LW +: LW]  = len;
    exp_gnt                 = NW'(1) << idx;
    tick();
    wr_req_i[idx] = 1'b0;
  endtask

  task automatic wr_beat(input int idx, input bit v, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input bit last);
    wr_valid_i[idx]         = v;
    wr_data_i[idx*DW +: DW] = data;
    exp_ready               = NW'(1) << idx;
    if (v) begin
      wr_q.push_back('{addr: addr, data: data});
      ref_mem[addr] = data;
      if (last) exp_done = NW'(1) << idx;
    end
    tick();
    wr_valid_i[idx] = 1'b0;
  endtask

  // Drives the command and queues expectations; the caller ticks.
  task automatic rd_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    rd_cmd_valid_i = 1'b1;
    rd_base_i      = base;
    rd_len_i       = len;
    chk_rdy        = 1'b1;
    exp_rdy        = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      a = base + AW'(i);
      rda_q.push_back(a);
      rd_q.push_back('{data: ref_mem[a], last: (i == int'(len))});
    end
  endtask

  function automatic logic [DW-1:0] dat(input int tag);
    return 64'hC0DE_0000_0000_0000 | 64'(tag);
  endfunction

  initial begin
    logic [AW-1:0] a;
    int            k;
    int            g;
    int            pat [5] = '{1, 0, 0, 1, 1};
    int            stl [5] = '{0, 1, 0, 0, 0};

    rst = 1'b1;
    #2;
    chk("rst_ub_write", 64'(ub_write_o), 64'd0);
    chk("rst_ub_read", 64'(ub_read_o), 64'd0);
    chk("rst_rd_cmd_ready", 64'(rd_cmd_ready_o), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_rd_data", rd_data_o, 64'd0);
    chk("rst_ub_addr_wr", 64'(ub_addr_wr_o), 64'd0);
    chk("rst_ub_addr_rd", 64'(ub_addr_rd_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    chk_rdy = 1'b1;
    exp_rdy = 1'b1;
    tick();

    // Reset in the middle of an 8-beat write burst.
    wr_cmd(0, 15'h0010, 8'd7);
    for (int b = 0; b < 3; b++) wr_beat(0, 1'b1, 15'h0010 + AW'(b), dat(16 + b), 1'b0);
    wr_valid_i[0]     = 1'b1;
    wr_data_i[0 +: DW] = dat(19);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wr_valid_i[0] = 1'b0;

    // Both held, single-beat bursts: pointer restarts at 0 and alternates.
    wr_req_i = 2'b11;
    wr_len_i = '0;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      wr_base_i[0 +: AW]  = 15'h0400 + AW'(i);
      wr_base_i[AW +: AW] = 15'h0500 + AW'(i);
      exp_gnt = NW'(1) << g;
      tick();
      a = (g == 0) ? 15'h0400 + AW'(i) : 15'h0500 + AW'(i);
      wr_beat(g, 1'b1, a, dat(32 + i), 1'b1);
    end
    wr_req_i = '0;

    // Address wrap at the top of the UB.
    wr_cmd(0, 15'h7FFE, 8'd3);
    for (int b = 0; b < 4; b++) begin
      a = 15'h7FFE + AW'(b);
      wr_beat(0, 1'b1, a, dat(48 + b), b == 3);
    end

    // Valid gaps: 3 beats over 5 cycles.
    wr_cmd(1, 15'h0300, 8'd2);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      wr_beat(1, pat[c] != 0, 15'h0300 + AW'(k), dat(64 + c), (pat[c] != 0) && (k == 2));
      if (pat[c] != 0) k++;
    end

    // Fill 0x0100..0x0103, then read it back with a stall on the second burst cycle.
    wr_cmd(0, 15'h0100, 8'd3);
    for (int b = 0; b < 4; b++) wr_beat(0, 1'b1, 15'h0100 + AW'(b), dat(80 + b), b == 3);
    rd_cmd(15'h0100, 8'd3);
    tick();
    rd_cmd_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rd_stall_i = stl[c] != 0;
      chk_rdy    = 1'b1;
      exp_rdy    = 1'b0;
      if (stl[c] != 0) begin
        chk_rdo = 1'b1;
        exp_rdo = 1'b0;
      end
      tick();
    end
    rd_stall_i = 1'b0;
    chk_rdy = 1'b1;
    exp_rdy = 1'b1;
    tick();
    tick();

    // Same-cycle write and read of 0x0200: read-first, then back-to-back reread sees new data.
    wr_cmd(1, 15'h0200, 8'd0);
    wr_beat(1, 1'b1, 15'h0200, dat(96), 1'b1);
    wr_req_i[0]           = 1'b1;
    wr_base_i[0 +: AW]    = 15'h0200;
    wr_len_i[0 +: LW]     = 8'd0;
    exp_gnt               = 2'b01;
    rd_cmd(15'h0200, 8'd0);
    tick();
    wr_req_i[0]    = 1'b0;
    rd_cmd_valid_i = 1'b0;
    chk_rdo = 1'b1;
    exp_rdo = 1'b1;
    chk_rdy = 1'b1;
    exp_rdy = 1'b0;
    wr_beat(0, 1'b1, 15'h0200, dat(97), 1'b1);
    rd_cmd(15'h0200, 8'd0);
    tick();
    rd_cmd_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) tick();

    chk("wr_q_left", 64'(wr_q.size()), 64'd0);
    chk("rd_addr_q_left", 64'(rda_q.size()), 64'd0);
    chk("rd_data_q_left", 64'(rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
